// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encodings and a
// ceiling-log2 helper used to size the settle counter.
package truth_table_sequencer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter: load starts a settle period of SETTLE cycles,
// expired_o is high on the last cycle of that period.
module tt_settle_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (clog2_f(SETTLE) < 1) ? 1 : clog2_f(SETTLE);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          expired_s;

  assign expired_s = (cnt_q == '0);
  assign expired_o = expired_s;

  // next count: clear beats load, load beats decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && !expired_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a combinational UUT through all 2^N_IN input vectors, captures its
// truth table and compares it against a latched expected table.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   y_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail
);

  localparam int TW = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TW - 1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

  logic [1:0]      state_q,   state_d;
  logic [N_IN-1:0] vec_q,     vec_d;
  logic [TW-1:0]   exp_q,     exp_d;
  logic [TW-1:0]   table_q,   table_d;
  logic [N_IN:0]   mis_q,     mis_d;
  logic [N_IN-1:0] ff_q,      ff_d;
  logic            ff_seen_q, ff_seen_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic            valid_q,   valid_d;
  logic            pass_q,    pass_d;

  logic tmr_clear_s;
  logic tmr_load_s;
  logic tmr_en_s;
  logic tmr_expired_s;

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear_s),
    .load_i   (tmr_load_s),
    .en_i     (tmr_en_s),
    .expired_o(tmr_expired_s)
  );

  // FSM, capture and compare next-state logic
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    exp_d       = exp_q;
    table_d     = table_q;
    mis_d       = mis_q;
    ff_d        = ff_q;
    ff_seen_d   = ff_seen_q;
    valid_d     = valid_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    tmr_clear_s = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start && !abort) begin
          exp_d      = expected;
          valid_d    = 1'b0;
          pass_d     = 1'b0;
          table_d    = '0;
          mis_d      = '0;
          ff_d       = '0;
          ff_seen_d  = 1'b0;
          tmr_load_s = 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          vec_d       = '0;
          valid_d     = 1'b0;
          pass_d      = 1'b0;
          tmr_clear_s = 1'b1;
        end else if (tmr_expired_s) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // abort wins over the capture of this vector
        if (abort) begin
          state_d     = ST_IDLE;
          vec_d       = '0;
          valid_d     = 1'b0;
          pass_d      = 1'b0;
          tmr_clear_s = 1'b1;
        end else begin
          table_d[vec_q] = y_in;
          if (y_in != exp_q[vec_q]) begin
            mis_d = mis_q + CNT_ONE;
            if (!ff_seen_q) begin
              ff_d      = vec_q;
              ff_seen_d = 1'b1;
            end else begin
              ff_d = ff_q;
            end
          end else begin
            mis_d = mis_q;
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_FINISH;
          end else begin
            vec_d      = vec_q + VEC_ONE;
            tmr_load_s = 1'b1;
            state_d    = ST_SETTLE;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        vec_d   = '0;
        if (abort) begin
          valid_d = 1'b0;
          pass_d  = 1'b0;
        end else begin
          done_d  = 1'b1;
          valid_d = 1'b1;
          pass_d  = (mis_q == '0);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        vec_d       = '0;
        tmr_clear_s = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      exp_q     <= '0;
      table_q   <= '0;
      mis_q     <= '0;
      ff_q      <= '0;
      ff_seen_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      exp_q     <= exp_d;
      table_q   <= table_d;
      mis_q     <= mis_d;
      ff_q      <= ff_d;
      ff_seen_q <= ff_seen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      pass_q    <= pass_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign valid        = valid_q;
  assign pass         = pass_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mis_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed, table-driven bench for truth_table_sequencer with defaults
// (N_IN = 3, SETTLE = 2); the UUT is a lookup table driven by vec_out.
module tb_truth_table_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       y_in;
  logic [2:0] vec_out;
  logic       busy;
  logic       done;
  logic       valid;
  logic       pass;
  logic [7:0] table_out;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail;

  logic [7:0] uut_tbl;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [7:0] uut;
    logic [7:0] expv;
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] cnt;
    logic [2:0] ff;
  } vec_t;

  vec_t vecs[6];

  truth_table_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .expected    (expected),
    .y_in        (y_in),
    .vec_out     (vec_out),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .pass        (pass),
    .table_out   (table_out),
    .mismatch_cnt(mismatch_cnt),
    .first_fail  (first_fail)
  );

  // UUT: a table lookup; 8'hEA is Y = A&B | C with A = vec_out[2]
  assign y_in = uut_tbl[vec_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({vec_out, busy, done, valid, pass, table_out, mismatch_cnt, first_fail}), 32'd0);
  endtask

  task automatic run_sweep(input vec_t v);
    int vec_err;
    int done_edge;
    int done_cnt;
    logic [2:0] want_vec;
    logic want_busy;
    vec_err   = 0;
    done_edge = -1;
    done_cnt  = 0;
    @(negedge clk);
    uut_tbl  = v.uut;
    expected = v.expv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j <= 23) want_vec = 3'(j / 3);
      else if (j == 24) want_vec = 3'd7;
      else want_vec = 3'd0;
      want_busy = (j <= 24);
      if (vec_out !== want_vec || busy !== want_busy) vec_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = j;
      end
    end
    check("vec_busy_seq", 32'(vec_err), 32'd0);
    check("done_edge", 32'(done_edge), 32'd25);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("valid", 32'(valid), 32'd1);
    check("table_out", 32'(table_out), 32'(v.tbl));
    check("pass", 32'(pass), 32'(v.pass));
    check("mismatch_cnt", 32'(mismatch_cnt), 32'(v.cnt));
    check("first_fail", 32'(first_fail), 32'(v.ff));
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    int t;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 8'h00;
    uut_tbl  = 8'hEA;

    vecs[0] = '{uut: 8'hEA, expv: 8'hEA, tbl: 8'hEA, pass: 1'b1, cnt: 4'd0, ff: 3'd0};
    vecs[1] = '{uut: 8'hEA, expv: 8'hE8, tbl: 8'hEA, pass: 1'b0, cnt: 4'd1, ff: 3'd1};
    vecs[2] = '{uut: 8'hEA, expv: 8'h15, tbl: 8'hEA, pass: 1'b0, cnt: 4'd8, ff: 3'd0};
    vecs[3] = '{uut: 8'hFF, expv: 8'h00, tbl: 8'hFF, pass: 1'b0, cnt: 4'd8, ff: 3'd0};
    vecs[4] = '{uut: 8'h81, expv: 8'h01, tbl: 8'h81, pass: 1'b0, cnt: 4'd1, ff: 3'd7};
    vecs[5] = '{uut: 8'h3C, expv: 8'h3C, tbl: 8'h3C, pass: 1'b1, cnt: 4'd0, ff: 3'd0};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");

    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i]);
    end

    // abort while vector 3 is applied
    @(negedge clk);
    uut_tbl  = 8'hEA;
    expected = 8'hEA;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (vec_out !== 3'd3 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("abort_reach_vec3", 32'(vec_out), 32'd3);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vec", 32'(vec_out), 32'd0);
    check("abort_valid_pass", 32'({valid, pass}), 32'd0);
    done_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_sweep(vecs[0]);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // start pulses while busy, expected changed mid-sweep, restart after done
    @(negedge clk);
    uut_tbl  = 8'hEA;
    expected = 8'hEA;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = -1;
    for (int j = 1; j <= 26; j++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && t < 0) t = j;
      if (j == 5) begin
        start    = 1'b1;
        expected = 8'h00;
      end else if (j == 10) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_start_done_edge", 32'(t), 32'd25);
    check("busy_start_result", 32'({table_out, pass, mismatch_cnt}), 32'({8'hEA, 1'b1, 4'd0}));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_after_done", 32'({busy, valid, vec_out}), 32'({1'b1, 1'b0, 3'd0}));
    done_cnt = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    check("restart_done", 32'(done_cnt), 32'd1);
    check("restart_result", 32'({table_out, pass, mismatch_cnt, first_fail}),
          32'({8'hEA, 1'b0, 4'd5, 3'd1}));

    // asynchronous reset mid-SETTLE
    @(negedge clk);
    uut_tbl  = 8'hFF;
    expected = 8'hFF;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("partial_table", 32'({busy, table_out, vec_out}), 32'({1'b1, 8'h03, 3'd2}));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_now");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("async_reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1 || done === 1'b1) busy_cnt++;
    end
    check("idle_after_release", 32'(busy_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
